id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS core.
- Sits between decode and execute. Captures the hazard-muxed control bundle (mem_write, mem_read, reg_write, reg_dst, mem_to_reg, ALU_src, ALU_op) plus the decode-stage operands, register indices and PC+4.
- Presents all captured values to EX, the forwarding unit and the hazard detection unit for one cycle per instruction.
- Supports stall (hold), flush (bubble), and a valid bit tracking real instructions.

Parameters:
- DATA_W, 32, width of operand, immediate and PC fields
- REG_AW, 5, register-index width
- CNT_W, 16, bubble-counter width (used only with the optional feature)

Ports:
- clk  input  1  clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- stall  input  1  hold all stored state this cycle
- flush  input  1  load a bubble this cycle (branch/jump squash)
- hazard_sel  input  1  hazard-mux select; 0 means the incoming control bundle is a stall bubble
- valid_in  input  1  decode stage holds a real instruction
- mem_write_in, mem_read_in, reg_write_in, reg_dst_in, mem_to_reg_in, ALU_src_in  input  1 each  muxed control
- ALU_op_in  input  3  muxed ALU op
- read_data1_in, read_data2_in, imm_in, pc4_in  input  DATA_W each  operands, sign-extended immediate, PC+4
- rs_in, rt_in, rd_in  input  REG_AW each  register indices
- matching *_out ports for every field above  output  same width  registered copies
- valid_out  output  1  EX holds a real instruction
- bubble_cnt  output  CNT_W  bubbles inserted (optional feature only)

Behaviour:
- Clock and reset: one clock domain, clk. rst is asynchronous and active-high.
- Reset: all outputs go to 0 immediately on rst assertion, regardless of clk: every control out, ALU_op_out=3'b000, all data/index outs, valid_out, bubble_cnt. Outputs hold 0 until the first rising edge after rst deasserts.
- Per-edge priority: rst > flush > stall > load.
- Flush: on the edge, the control outs, ALU_op_out and valid_out become 0. Data/index outs become 0 as well, so forwarding never matches a stale rd.
- Stall (flush=0): every output holds its value, including valid_out.
- Load (flush=0, stall=0):
  - All *_out <= *_in.
  - valid_out <= valid_in & hazard_sel.
  - When hazard_sel=0, the control outs are loaded as the zeros already produced upstream. The register does not re-zero them. Data fields still load.
- Latency: exactly 1 cycle from inputs to outputs on a load edge. There are no combinational paths from inputs to outputs.
- Simultaneous stall=1 and flush=1: flush wins and a bubble is loaded.
- The register stores ALU_op and the data fields verbatim. It does no arithmetic.
- Reset asserted mid-stall: clears immediately. After release, the register loads normally on the first edge with stall=0.

Optional Feature:
- Macro: ID_EX_BUBBLE_CNT_EN.
- When defined:
  - bubble_cnt increments by 1 on every non-reset edge that loads a bubble, i.e. flush=1, or (stall=0 and hazard_sel=0).
  - The counter saturates at 2^CNT_W-1 and does not wrap.
  - Reset clears it to 0.
  - A stall with flush=0 does not count.
- When not defined: no counter flops exist and bubble_cnt is tied to 0.

Test Plan:
- Reset: assert rst mid-cycle after loading read_data1_in=32'hDEADBEEF -> all outputs 0 before the next edge. After release, outputs stay 0 until the first load edge.
- Load: valid_in=1, hazard_sel=1, ALU_op_in=3'b010, reg_write_in=1, rd_in=5'd9, imm_in=32'hFFFF_FFF0 -> next edge gives identical outs and valid_out=1.
- Stall: load pc4_in=32'h0000_0010, then stall=1 for 3 cycles while pc4_in changes to 32'h14/18/1C -> pc4_out stays 32'h10 for all 3 cycles; the first edge after stall drops loads 32'h1C.
- Load-use bubble: hazard_sel=0 with zeroed controls and rd_in=5'd4 -> reg_write_out=0, valid_out=0, rd_out=4. With ID_EX_BUBBLE_CNT_EN defined, bubble_cnt increments 0->1.
- Flush vs stall: stall=1 and flush=1 on the same edge, previously holding reg_write_out=1 and rd_out=7 -> reg_write_out=0, rd_out=0, valid_out=0; bubble_cnt increments.
- Saturation, with CNT_W=2 and the feature enabled: 5 consecutive flush edges -> bubble_cnt reads 1,2,3,3,3.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures the decode-stage control bundle, operands and indices for EX.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              hazard_sel,
    input  logic              valid_in,
    input  logic              mem_write_in,
    input  logic              mem_read_in,
    input  logic              reg_write_in,
    input  logic              reg_dst_in,
    input  logic              mem_to_reg_in,
    input  logic              ALU_src_in,
    input  logic [2:0]        ALU_op_in,
    input  logic [DATA_W-1:0] read_data1_in,
    input  logic [DATA_W-1:0] read_data2_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [DATA_W-1:0] pc4_in,
    input  logic [REG_AW-1:0] rs_in,
    input  logic [REG_AW-1:0] rt_in,
    input  logic [REG_AW-1:0] rd_in,
    output logic              mem_write_out,
    output logic              mem_read_out,
    output logic              reg_write_out,
    output logic              reg_dst_out,
    output logic              mem_to_reg_out,
    output logic              ALU_src_out,
    output logic [2:0]        ALU_op_out,
    output logic [DATA_W-1:0] read_data1_out,
    output logic [DATA_W-1:0] read_data2_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [DATA_W-1:0] pc4_out,
    output logic [REG_AW-1:0] rs_out,
    output logic [REG_AW-1:0] rt_out,
    output logic [REG_AW-1:0] rd_out,
    output logic              valid_out,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic              mem_write;
        logic              mem_read;
        logic              reg_write;
        logic              reg_dst;
        logic              mem_to_reg;
        logic              alu_src;
        logic [2:0]        alu_op;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc4;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic              valid;
    } idex_t;

    idex_t in_s;
    idex_t bundle_d;
    idex_t bundle_q;

    // Control bits arrive already zeroed by the hazard mux; only valid is qualified here.
    always_comb begin
        in_s.mem_write  = mem_write_in;
        in_s.mem_read   = mem_read_in;
        in_s.reg_write  = reg_write_in;
        in_s.reg_dst    = reg_dst_in;
        in_s.mem_to_reg = mem_to_reg_in;
        in_s.alu_src    = ALU_src_in;
        in_s.alu_op     = ALU_op_in;
        in_s.rd1        = read_data1_in;
        in_s.rd2        = read_data2_in;
        in_s.imm        = imm_in;
        in_s.pc4        = pc4_in;
        in_s.rs         = rs_in;
        in_s.rt         = rt_in;
        in_s.rd         = rd_in;
        in_s.valid      = valid_in & hazard_sel;
    end

    // Flush clears data/index fields too so forwarding never matches a stale rd.
    always_comb begin
        bundle_d = bundle_q;
        if (flush)
            bundle_d = '0;
        else if (!stall)
            bundle_d = in_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bundle_q <= '0;
        else
            bundle_q <= bundle_d;
    end

    assign mem_write_out  = bundle_q.mem_write;
    assign mem_read_out   = bundle_q.mem_read;
    assign reg_write_out  = bundle_q.reg_write;
    assign reg_dst_out    = bundle_q.reg_dst;
    assign mem_to_reg_out = bundle_q.mem_to_reg;
    assign ALU_src_out    = bundle_q.alu_src;
    assign ALU_op_out     = bundle_q.alu_op;
    assign read_data1_out = bundle_q.rd1;
    assign read_data2_out = bundle_q.rd2;
    assign imm_out        = bundle_q.imm;
    assign pc4_out        = bundle_q.pc4;
    assign rs_out         = bundle_q.rs;
    assign rt_out         = bundle_q.rt;
    assign rd_out         = bundle_q.rd;
    assign valid_out      = bundle_q.valid;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic             bubble_ld;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // A bubble is either a squash or a hazard-mux bubble that actually loads.
    assign bubble_ld = flush | (~stall & ~hazard_sel);

    always_comb begin
        cnt_d = cnt_q;
        if (bubble_ld && !(&cnt_q))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign bubble_cnt = cnt_q;
`else
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg (bubble counter built with CNT_W=2).
module tb_id_ex_pipe_reg;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 2;
`ifdef ID_EX_BUBBLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, stall, flush, hazard_sel, valid_in;
    logic mem_write_in, mem_read_in, reg_write_in, reg_dst_in, mem_to_reg_in, ALU_src_in;
    logic [2:0] ALU_op_in;
    logic [DATA_W-1:0] read_data1_in, read_data2_in, imm_in, pc4_in;
    logic [REG_AW-1:0] rs_in, rt_in, rd_in;
    logic mem_write_out, mem_read_out, reg_write_out, reg_dst_out, mem_to_reg_out, ALU_src_out;
    logic [2:0] ALU_op_out;
    logic [DATA_W-1:0] read_data1_out, read_data2_out, imm_out, pc4_out;
    logic [REG_AW-1:0] rs_out, rt_out, rd_out;
    logic valid_out;
    logic [CNT_W-1:0] bubble_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .hazard_sel(hazard_sel),
        .valid_in(valid_in), .mem_write_in(mem_write_in), .mem_read_in(mem_read_in),
        .reg_write_in(reg_write_in), .reg_dst_in(reg_dst_in), .mem_to_reg_in(mem_to_reg_in),
        .ALU_src_in(ALU_src_in), .ALU_op_in(ALU_op_in), .read_data1_in(read_data1_in),
        .read_data2_in(read_data2_in), .imm_in(imm_in), .pc4_in(pc4_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
        .mem_write_out(mem_write_out), .mem_read_out(mem_read_out),
        .reg_write_out(reg_write_out), .reg_dst_out(reg_dst_out),
        .mem_to_reg_out(mem_to_reg_out), .ALU_src_out(ALU_src_out), .ALU_op_out(ALU_op_out),
        .read_data1_out(read_data1_out), .read_data2_out(read_data2_out),
        .imm_out(imm_out), .pc4_out(pc4_out), .rs_out(rs_out), .rt_out(rt_out),
        .rd_out(rd_out), .valid_out(valid_out), .bubble_cnt(bubble_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] exp_cnt(input int n);
        return CNT_EN ? 64'(n) : 64'd0;
    endfunction

    task automatic clear_inputs();
        {mem_write_in, mem_read_in, reg_write_in, reg_dst_in, mem_to_reg_in, ALU_src_in} = '0;
        ALU_op_in = 3'b000;
        read_data1_in = '0; read_data2_in = '0; imm_in = '0; pc4_in = '0;
        rs_in = '0; rt_in = '0; rd_in = '0;
        valid_in = 1'b0;
        hazard_sel = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {58'd0, mem_write_out, mem_read_out, reg_write_out, reg_dst_out,
                            mem_to_reg_out, ALU_src_out}, 64'd0);
        chk({tag, "_op"}, 64'(ALU_op_out), 64'd0);
        chk({tag, "_rd1"}, 64'(read_data1_out), 64'd0);
        chk({tag, "_dat"}, 64'(read_data2_out | imm_out | pc4_out), 64'd0);
        chk({tag, "_idx"}, 64'({rs_out, rt_out, rd_out}), 64'd0);
        chk({tag, "_vld"}, 64'(valid_out), 64'd0);
        chk({tag, "_cnt"}, 64'(bubble_cnt), 64'd0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        clear_inputs();
        #12;
        chk_all_zero("por");
        rst = 1'b0;

        // Load DEADBEEF, then assert reset mid-cycle
        read_data1_in = 32'hDEADBEEF; valid_in = 1'b1;
        tick();
        chk("rd1_load", 64'(read_data1_out), 64'hDEADBEEF);
        chk("vld_load", 64'(valid_out), 64'd1);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        stall = 1'b1;
        #1 rst = 1'b0;
        tick();
        chk("post_rst_stall_rd1", 64'(read_data1_out), 64'd0);
        chk("post_rst_stall_vld", 64'(valid_out), 64'd0);
        stall = 1'b0;

        // Full load
        valid_in = 1'b1; hazard_sel = 1'b1; ALU_op_in = 3'b010; reg_write_in = 1'b1;
        rd_in = 5'd9; imm_in = 32'hFFFF_FFF0; rs_in = 5'd3; rt_in = 5'd17;
        mem_read_in = 1'b1; ALU_src_in = 1'b1; read_data2_in = 32'h1234_5678; pc4_in = 32'h100;
        tick();
        chk("ld_op", 64'(ALU_op_out), 64'd2);
        chk("ld_regw", 64'(reg_write_out), 64'd1);
        chk("ld_memr", 64'(mem_read_out), 64'd1);
        chk("ld_memw", 64'(mem_write_out), 64'd0);
        chk("ld_alusrc", 64'(ALU_src_out), 64'd1);
        chk("ld_rd", 64'(rd_out), 64'd9);
        chk("ld_rs", 64'(rs_out), 64'd3);
        chk("ld_rt", 64'(rt_out), 64'd17);
        chk("ld_imm", 64'(imm_out), 64'hFFFF_FFF0);
        chk("ld_rd2", 64'(read_data2_out), 64'h1234_5678);
        chk("ld_pc4", 64'(pc4_out), 64'h100);
        chk("ld_vld", 64'(valid_out), 64'd1);
        chk("ld_cnt", 64'(bubble_cnt), 64'd0);

        // Stall holds for 3 cycles while inputs move
        pc4_in = 32'h10;
        tick();
        chk("st_pre", 64'(pc4_out), 64'h10);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc4_in = 32'h14 + 32'(4 * i);
            valid_in = 1'b0;
            tick();
            chk("st_hold_pc4", 64'(pc4_out), 64'h10);
            chk("st_hold_vld", 64'(valid_out), 64'd1);
        end
        stall = 1'b0;
        tick();
        chk("st_release_pc4", 64'(pc4_out), 64'h1C);
        chk("st_release_vld", 64'(valid_out), 64'd0);

        // Load-use bubble from the hazard mux
        clear_inputs();
        valid_in = 1'b1; hazard_sel = 1'b0; rd_in = 5'd4;
        tick();
        chk("lu_regw", 64'(reg_write_out), 64'd0);
        chk("lu_vld", 64'(valid_out), 64'd0);
        chk("lu_rd", 64'(rd_out), 64'd4);
        chk("lu_cnt", 64'(bubble_cnt), exp_cnt(1));

        // Flush wins over stall
        hazard_sel = 1'b1; reg_write_in = 1'b1; rd_in = 5'd7; ALU_op_in = 3'b110;
        tick();
        chk("fs_pre_regw", 64'(reg_write_out), 64'd1);
        chk("fs_pre_rd", 64'(rd_out), 64'd7);
        stall = 1'b1; flush = 1'b1;
        tick();
        chk("fs_regw", 64'(reg_write_out), 64'd0);
        chk("fs_rd", 64'(rd_out), 64'd0);
        chk("fs_op", 64'(ALU_op_out), 64'd0);
        chk("fs_vld", 64'(valid_out), 64'd0);
        chk("fs_cnt", 64'(bubble_cnt), exp_cnt(2));
        stall = 1'b0; flush = 1'b0;

        // Counter saturation from a fresh reset
        #2 rst = 1'b1;
        #1 chk("sat_rst_cnt", 64'(bubble_cnt), 64'd0);
        rst = 1'b0;
        flush = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("sat_cnt", 64'(bubble_cnt), exp_cnt(i > 3 ? 3 : i));
        end
        flush = 1'b0;
        stall = 1'b1; hazard_sel = 1'b0;
        tick();
        chk("sat_stall_nocount", 64'(bubble_cnt), exp_cnt(3));
        stall = 1'b0; hazard_sel = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
